// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Runtime-programmable clock divider. Produces a registered divided clock
// (clk_out, period 2*div_cur system clocks, 50% duty) plus a one-cycle
// strobe (tick) in the first cycle clk_out is high. A new half-period is
// offered over a valid/ready handshake. In IDLE it takes effect at once.
// While running it is parked and applied only at the next low-to-high
// boundary of clk_out, so no runt pulses are produced. A half-period of 0
// stops the divided clock after the current low phase.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   cfg_valid  in   a new half-period value is offered
//   cfg_div    in   half-period in clk cycles (0 = stop)
//   cfg_ready  out  a config can be accepted this cycle (state != PEND)
//   cfg_done   out  one-cycle pulse when an accepted config takes effect
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse in the first cycle clk_out is 1
//   running    out  high in RUN and PEND
//   div_cur    out  half-period currently in force (0 when idle)
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] div_cur
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] div_cur_q,  div_cur_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             clk_out_q,  clk_out_d;
    logic             tick_q,     tick_d;
    logic             cfg_done_q, cfg_done_d;

    logic             xfer;
    logic             half_end;

    assign cfg_ready = (state_q != S_PEND);
    assign xfer      = cfg_valid & cfg_ready;

    // Last cycle of the current half-period. div_cur_q is never 0 outside
    // IDLE, so the subtraction cannot wrap while this is used.
    assign half_end  = (cnt_q == (div_cur_q - ONE));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that paths
        // that do not assign it hold state instead of inferring a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_div_d = pend_div_q;
        clk_out_d  = clk_out_q;
        cfg_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d     = ZERO;
                clk_out_d = 1'b0;
                if (xfer) begin
                    cfg_done_d = 1'b1;
                    if (cfg_div != ZERO) begin
                        state_d   = S_RUN;
                        div_cur_d = cfg_div;
                    end
                end
            end

            S_RUN: begin
                if (half_end) begin
                    clk_out_d = ~clk_out_q;
                    cnt_d     = ZERO;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                // A transfer coincident with a rising boundary lets that
                // boundary complete with the old ratio; the value waits for
                // the next rise.
                if (xfer) begin
                    pend_div_d = cfg_div;
                    state_d    = S_PEND;
                end
            end

            S_PEND: begin
                if (half_end) begin
                    cnt_d = ZERO;
                    if (!clk_out_q) begin
                        // Rising boundary: apply the parked value. The high
                        // phase that starts here already uses the new ratio.
                        cfg_done_d = 1'b1;
                        if (pend_div_q != ZERO) begin
                            clk_out_d = 1'b1;
                            div_cur_d = pend_div_q;
                            state_d   = S_RUN;
                        end else begin
                            clk_out_d = 1'b0;
                            div_cur_d = ZERO;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        // Falling boundary toggles normally.
                        clk_out_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                cnt_d     = ZERO;
                div_cur_d = ZERO;
                clk_out_d = 1'b0;
            end
        endcase
    end

    // tick marks the cycle in which the registered clk_out has just risen.
    assign tick_d = clk_out_d & ~clk_out_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= ZERO;
            div_cur_q  <= ZERO;
            pend_div_q <= ZERO;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_div_q <= pend_div_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign cfg_done = cfg_done_q;
    assign div_cur  = div_cur_q;
    assign running  = (state_q != S_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed and randomized stimulus for clk_div_ctrl. Expected outputs come
// from a timeline model: the divided clock is described by its level, the
// half-period in force, and the absolute cycle number of its next edge. A
// parked config is applied at the first edge where the level would rise.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int WIDTH = 8;
    localparam int BOUND = 600;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_done;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [WIDTH-1:0] div_cur;

    int n_cmp  = 0;
    int n_fail = 0;

    clk_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .div_cur   (div_cur)
    );

    always #5 clk = ~clk;

    // Timeline model state
    int  n      = 0;  // posedge index
    bit  m_run  = 0;  // divided clock active
    bit  m_lvl  = 0;  // clk_out level
    int  m_div  = 0;  // half-period in force
    int  m_next = 0;  // posedge index of next clk_out edge
    bit  m_pv   = 0;  // config parked
    int  m_pval = 0;  // parked half-period
    bit  m_tick = 0;
    bit  m_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, n, got, exp);
        end
    endtask

    // Advance the model by one posedge using the inputs presented at it.
    task automatic model_edge();
        bit xfer;
        n++;
        xfer   = cfg_valid && !m_pv;
        m_tick = 0;
        m_done = 0;
        if (reset) begin
            m_run = 0; m_lvl = 0; m_div = 0; m_pv = 0; m_pval = 0;
        end else if (!m_run) begin
            if (xfer) begin
                m_done = 1;
                if (cfg_div != 0) begin
                    m_run  = 1;
                    m_lvl  = 0;
                    m_div  = int'(cfg_div);
                    m_next = n + int'(cfg_div);
                end
            end
        end else begin
            if (n == m_next) begin
                if (!m_lvl && m_pv) begin
                    m_pv   = 0;
                    m_done = 1;
                    if (m_pval != 0) begin
                        m_lvl  = 1;
                        m_tick = 1;
                        m_div  = m_pval;
                        m_next = n + m_pval;
                    end else begin
                        m_run = 0;
                        m_div = 0;
                    end
                end else begin
                    m_lvl  = !m_lvl;
                    m_tick = m_lvl;
                    m_next = n + m_div;
                end
            end
            if (xfer) begin
                m_pv   = 1;
                m_pval = int'(cfg_div);
            end
        end
    endtask

    // One clock: advance model at the edge, compare all outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("clk_out",   32'(clk_out),   32'(m_lvl));
        check("tick",      32'(tick),      32'(m_tick));
        check("cfg_done",  32'(cfg_done),  32'(m_done));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
        check("running",   32'(running),   32'(m_run));
        check("div_cur",   32'(div_cur),   32'(m_div));
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Hold cfg_valid until the model accepts the transfer.
    task automatic send_cfg(input int div);
        bit acc = 0;
        int k   = 0;
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(div);
        while (!acc && k < BOUND) begin
            acc = !m_pv;
            step();
            k++;
        end
        cfg_valid = 1'b0;
        check("send_cfg_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!m_done && k < BOUND) begin
            step();
            k++;
        end
        check("wait_done_seen", 32'(m_done), 32'd1);
    endtask

    initial begin
        int k;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // Reset for two cycles
        steps(2);
        check("reset_clk_out",   32'(clk_out),   32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_div_cur",   32'(div_cur),   32'd0);
        reset = 1'b0;
        steps(2);

        // Divide by 2: toggles every cycle, rise at E0+1
        send_cfg(1);
        check("div1_done_after_e0", 32'(cfg_done), 32'd1);
        steps(8);
        check("div1_div_cur", 32'(div_cur), 32'd1);

        // 1 -> 2, three periods, then 2 -> 4 at a rising boundary
        send_cfg(2);
        wait_done();
        steps(12);
        send_cfg(4);
        wait_done();
        check("div4_done_with_tick", 32'(tick), 32'd1);
        check("div4_high_at_apply",  32'(clk_out), 32'd1);
        steps(10);

        // 4 -> 3, then stop with 0
        send_cfg(3);
        wait_done();
        steps(6);
        send_cfg(0);
        wait_done();
        steps(8);
        check("stop_running", 32'(running), 32'd0);
        check("stop_div_cur", 32'(div_cur),  32'd0);
        check("stop_clk_out", 32'(clk_out),  32'd0);

        // Transfer exactly on a rising boundary (2 -> 5)
        send_cfg(2);
        k = 0;
        while (!(m_run && !m_pv && !m_lvl && m_next == n + 1) && k < BOUND) begin
            step();
            k++;
        end
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(5);
        step();
        check("boundary_keeps_old", 32'(div_cur), 32'd2);
        check("boundary_rise",      32'(clk_out), 32'd1);
        // A second offer during PEND must be ignored.
        cfg_div = WIDTH'(7);
        steps(3);
        cfg_valid = 1'b0;
        wait_done();
        check("boundary_applied_next", 32'(div_cur), 32'd5);
        steps(6);

        // Reset mid-high-phase with a config parked
        k = 0;
        while (!(m_lvl && m_next > n + 2) && k < BOUND) begin
            step();
            k++;
        end
        send_cfg(6);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_clk_out",   32'(clk_out),   32'd0);
        check("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_mid_running",   32'(running),   32'd0);
        steps(16);
        check("rst_mid_never_applied", 32'(div_cur), 32'd0);

        // Zero in IDLE
        send_cfg(0);
        check("idle_zero_done",    32'(cfg_done), 32'd1);
        check("idle_zero_running", 32'(running),  32'd0);
        steps(4);

        // Randomized configs, gaps and occasional resets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else begin
                send_cfg(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
            end
            steps(int'($urandom_range(0, 12)));
        end
        steps(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
